// File: rtl/div_pkg.sv
// div_pkg: shared widths, limits and FSM state type for the iterative divider.
package div_pkg;
    localparam int          DIV_W       = 32;
    localparam logic [5:0]  DIV_CNT_MAX = 6'd32;
    localparam int          DIV_RES_W   = 64;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} div_state_t;
endpackage

// File: rtl/div_if.sv
// div_if: EX-stage <-> divider handshake bundle.
//   master (EX side): drives signed_div, opdata1, opdata2, start, annul;
//                     receives result {rem, quot} and ready.
//   slave  (divider): the mirror image.
import div_pkg::*;

interface div_if;
    logic                 signed_div;
    logic [DIV_W-1:0]     opdata1;
    logic [DIV_W-1:0]     opdata2;
    logic                 start;
    logic                 annul;
    logic [DIV_RES_W-1:0] result;
    logic                 ready;

    modport master (output signed_div, opdata1, opdata2, start, annul,
                    input  result, ready);
    modport slave  (input  signed_div, opdata1, opdata2, start, annul,
                    output result, ready);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (combinational).
//   dend_i    : 65-bit partial remainder / quotient shift register
//   divisor_i : divisor magnitude
//   dend_o    : shift register after this iteration
import div_pkg::*;

module div_step (
    input  logic [2*DIV_W:0]  dend_i,
    input  logic [DIV_W-1:0]  divisor_i,
    output logic [2*DIV_W:0]  dend_o
);
    logic [DIV_W:0] diff;

    always_comb begin
        diff = dend_i[2*DIV_W:DIV_W] - {1'b0, divisor_i};
        // Borrow out means the divisor did not fit: restore by plain shift.
        if (diff[DIV_W])
            dend_o = {dend_i[2*DIV_W-1:0], 1'b0};
        else
            dend_o = {diff[DIV_W-1:0], dend_i[DIV_W-1:0], 1'b1};
    end
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider (DIV/DIVU) for EX.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : div_if.slave -- operands/start/annul in, result/ready out
//   result   : {remainder, quotient}, registered; ready registered.
// Build macro DIV_SIGNED_EN: when defined, signed_div selects two's
// complement division; otherwise every division is unsigned.
import div_pkg::*;

module div_unit (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    div_state_t           state_q;
    logic [2*DIV_W:0]     dend_q;
    logic [2*DIV_W:0]     dend_d;
    logic [DIV_W-1:0]     divisor_q;
    logic [5:0]           cnt_q;
    logic [DIV_RES_W-1:0] result_q;
    logic                 ready_q;

    logic [DIV_W-1:0]     mag1, mag2;
    logic [DIV_W-1:0]     quot_fin, rem_fin;

`ifdef DIV_SIGNED_EN
    logic neg1_q, neg2_q;
    logic neg1_d, neg2_d;

    assign neg1_d   = bus.signed_div & bus.opdata1[DIV_W-1];
    assign neg2_d   = bus.signed_div & bus.opdata2[DIV_W-1];
    assign mag1     = neg1_d ? (~bus.opdata1 + 1'b1) : bus.opdata1;
    assign mag2     = neg2_d ? (~bus.opdata2 + 1'b1) : bus.opdata2;
    // Quotient truncates toward zero; remainder follows the dividend sign.
    assign quot_fin = (neg1_q ^ neg2_q) ? (~dend_q[DIV_W-1:0] + 1'b1)
                                        : dend_q[DIV_W-1:0];
    assign rem_fin  = neg1_q ? (~dend_q[2*DIV_W:DIV_W+1] + 1'b1)
                             : dend_q[2*DIV_W:DIV_W+1];
`else
    assign mag1     = bus.opdata1;
    assign mag2     = bus.opdata2;
    assign quot_fin = dend_q[DIV_W-1:0];
    assign rem_fin  = dend_q[2*DIV_W:DIV_W+1];
`endif

    div_step u_step (
        .dend_i    (dend_q),
        .divisor_i (divisor_q),
        .dend_o    (dend_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FREE;
            dend_q    <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                FREE: begin
                    result_q <= '0;
                    ready_q  <= 1'b0;
                    if (bus.start && !bus.annul) begin
                        if (bus.opdata2 == '0) begin
                            state_q <= BYZERO;
                        end else begin
                            divisor_q <= mag2;
                            dend_q    <= {{DIV_W{1'b0}}, mag1, 1'b0};
                            cnt_q     <= '0;
`ifdef DIV_SIGNED_EN
                            neg1_q    <= neg1_d;
                            neg2_q    <= neg2_d;
`endif
                            state_q   <= ON;
                        end
                    end
                end
                BYZERO: begin
                    if (bus.annul) begin
                        state_q <= FREE;
                    end else begin
                        result_q <= '0;
                        ready_q  <= 1'b1;
                        state_q  <= END;
                    end
                end
                ON: begin
                    if (bus.annul) begin
                        cnt_q   <= '0;
                        state_q <= FREE;
                    end else if (cnt_q != DIV_CNT_MAX) begin
                        dend_q <= dend_d;
                        cnt_q  <= cnt_q + 6'd1;
                    end else begin
                        result_q <= {rem_fin, quot_fin};
                        ready_q  <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= END;
                    end
                end
                END: begin
                    // Result is held for EX until it drops start.
                    if (!bus.start) begin
                        result_q <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= FREE;
                    end
                end
                default: state_q <= FREE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.ready  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for div_unit.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] sb[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_u(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

    // Launch one division, check latency, result, hold and release.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp, input int lat);
        int n;
        logic [63:0] e;
        sb.push_back(exp);
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.signed_div = sgn;
        bus.start      = 1'b1;
        @(posedge clk); #1;                 // edge 1
        // Operands must be latched on edge 1; scramble them afterwards.
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom | 32'h1;
        bus.signed_div = ~sgn;
        n = 1;
        while (!bus.ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        e = sb.pop_front();
        chk({tag, "_res"}, bus.result, e);
        @(posedge clk); #1;
        chk({tag, "_hold"}, {63'd0, bus.ready}, 64'd1);
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rdy0"}, {63'd0, bus.ready}, 64'd0);
        chk({tag, "_res0"}, bus.result, 64'd0);
    endtask

    initial begin
        logic seen;
        logic [31:0] ra, rb;
        bus.start = 1'b0; bus.annul = 1'b0; bus.signed_div = 1'b0;
        bus.opdata1 = '0; bus.opdata2 = '0;

        rst = 1'b1;
        #1;
        chk("reset_rdy", {63'd0, bus.ready}, 64'd0);
        chk("reset_res", bus.result, 64'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        do_div("u100_7", 32'd100, 32'd7, 1'b0, model_u(32'd100, 32'd7), 34);
        chk("u100_7_const", model_u(32'd100, 32'd7), {32'h2, 32'hE});
        do_div("uffff_1", 32'hFFFFFFFF, 32'd1, 1'b0, model_u(32'hFFFFFFFF, 32'd1), 34);
`ifdef DIV_SIGNED_EN
        do_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
        do_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, {32'h1, 32'hFFFFFFFD}, 34);
        do_div("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 34);
`else
        do_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'h1, 32'h7FFFFFFC}, 34);
        do_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, model_u(32'd7, 32'hFFFFFFFE), 34);
        do_div("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1,
               model_u(32'h80000000, 32'hFFFFFFFF), 34);
`endif
        do_div("divzero", 32'd1234, 32'd0, 1'b0, 64'd0, 2);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 70000);
            do_div("urand", ra, rb, 1'b0, model_u(ra, rb), 34);
        end

        // annul while ON: sampled on edge 12
        bus.opdata1 = 32'd100; bus.opdata2 = 32'd7; bus.signed_div = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;                 // edge 1
        repeat (10) begin @(posedge clk); #1; end
        bus.annul = 1'b1; bus.start = 1'b0;
        @(posedge clk); #1;                 // edge 12
        bus.annul = 1'b0;
        seen = bus.ready;
        repeat (40) begin @(posedge clk); #1; seen |= bus.ready; end
        chk("annul_noready", {63'd0, seen}, 64'd0);
        do_div("after_annul", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 34);

        // annul together with start in FREE: nothing starts
        bus.annul = 1'b1; bus.start = 1'b1; bus.opdata2 = 32'd0;
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; seen |= bus.ready; end
        chk("annul_start_free", {63'd0, seen}, 64'd0);
        bus.annul = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;

        // rst pulse mid-ON
        bus.opdata1 = 32'd100; bus.opdata2 = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        repeat (8) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("rst_on_rdy", {63'd0, bus.ready}, 64'd0);
        chk("rst_on_res", bus.result, 64'd0);
        bus.start = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // rst while a result is held: must clear without waiting for a clock
        bus.opdata1 = 32'd50; bus.opdata2 = 32'd5; bus.start = 1'b1;
        @(posedge clk); #1;
        repeat (34) begin @(posedge clk); #1; end
        chk("pre_rst_end_res", bus.result, model_u(32'd50, 32'd5));
        #2 rst = 1'b1;
        #1;
        chk("rst_end_rdy", {63'd0, bus.ready}, 64'd0);
        chk("rst_end_res", bus.result, 64'd0);
        bus.start = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        do_div("after_rst", 32'd81, 32'd9, 1'b0, model_u(32'd81, 32'd9), 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 restoring divider for the EX stage. It executes DIV/DIVU over 32 iterations and returns a 64-bit {remainder, quotient} result. EX stalls the pipeline while a division is in flight. The result travels through MEM/WB: the upper word (remainder) is written to HI and the lower word (quotient) to LO.

## Interface
Parameters:
- none; widths are fixed by package constants.

Ports:
- clk, in, 1, clock; all state changes on the rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- signed_div, in, 1, 1 = DIV (two's complement), 0 = DIVU; sampled with start.
- opdata1, in, 32, dividend; sampled with start.
- opdata2, in, 32, divisor; sampled with start.
- start, in, 1, request; held high by EX until ready is seen.
- annul, in, 1, cancel the in-flight division (pipeline flush).
- result, out, 64, {remainder[31:0], quotient[31:0]}.
- ready, out, 1, result valid.

## Operation
States: FREE, BYZERO, ON, END. Internal registers:
- 65-bit shift register dend
- latched divisor
- sign bits of both operands
- 6-bit counter cnt

**FREE**
- If start=1 and annul=0 and opdata2=0: go to BYZERO.
- Else if start=1 and annul=0:
  - latch operands; when signed, take the magnitude of each negative operand;
  - dend <= {32'b0, |opdata1|, 1'b0}; cnt <= 0; go to ON.
- Otherwise stay in FREE; ready=0, result=0.

**BYZERO**
- If annul=1: go to FREE.
- Else: result <= 0, ready <= 1, go to END.

**ON**
- If annul=1: go to FREE, cnt <= 0; result and ready stay 0.
- Else if cnt != 32, do one iteration:
  - diff = dend[64:32] - {1'b0, divisor} (33 bits);
  - if diff[32]=1: dend <= {dend[63:0], 1'b0};
  - else: dend <= {diff[31:0], dend[31:0], 1'b1};
  - cnt <= cnt + 1.
- Else (cnt = 32), finalise:
  - quotient = dend[31:0]; remainder = dend[64:33];
  - when signed and the operand signs differ, negate the quotient;
  - when signed and the dividend is negative, negate the remainder;
  - result <= {rem, quot}, ready <= 1, cnt <= 0, go to END.

**END**
- Hold result and ready while start=1; annul is ignored here.
- When start=0: result <= 0, ready <= 0, go to FREE.

Arithmetic rules:
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- The remainder takes the sign of the dividend; the quotient truncates toward zero.

## Timing
- Reset: state FREE, result 64'h0, ready 0, cnt 0, dend 0.
- Count edges from the first edge that samples start=1 as edge 1.
- Normal division: iterations run on edges 2..33; ready=1 after edge 34 (34 cycles).
- Divide by zero: ready=1 after edge 2.
- ready is registered and is never asserted combinationally.
- After ready is seen, EX drops start. Deassertion takes one edge; a new start is accepted on the following edge from FREE.
- Operand changes after edge 1 have no effect on the result.
- annul and start together in FREE: annul wins, no division starts.
- rst mid-operation returns to the reset state immediately.

## Configuration
- DIV_SIGNED_EN defined: signed_div is honoured (magnitude pre-processing and sign fix-up are present).
- DIV_SIGNED_EN undefined: signed_div is ignored; every division is unsigned, and the negation logic and sign registers are removed. Latency is unchanged.

## Structure
- Package div_pkg holds:
  - state enum div_state_t {FREE, BYZERO, ON, END};
  - DIV_W = 32;
  - DIV_CNT_MAX = 6'd32;
  - DIV_RES_W = 64.
- One sub-module: div_step, combinational, 65-bit dend plus 32-bit divisor in, next dend out. It performs the single restoring iteration and is instantiated once.

## Test plan
- Unsigned 100 / 7:
  - result = {32'h2, 32'hE};
  - ready rises after edge 34 and holds until start drops, then returns to 0 with result 0.
- Signed -7 / 2: result = {32'hFFFFFFFF, 32'hFFFFFFFD}. Signed 7 / -2: result = {32'h1, 32'hFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF: result = {32'h0, 32'h80000000}. Unsigned 0xFFFFFFFF / 1: result = {32'h0, 32'hFFFFFFFF}.
- Divide by zero: opdata2 = 0 gives result 0 and ready after edge 2.
- annul asserted at edge 12 while in ON:
  - the unit returns to FREE and ready never rises;
  - a following start with 9 / 3 yields {0, 3} after 34 edges.
- rst pulsed mid-ON: ready=0 and result=0 immediately. With DIV_SIGNED_EN undefined, -7 / 2 returns the unsigned result {32'h1, 32'h7FFFFFFC}.
